// File: rtl/accum_unit_if.sv
// accum_unit_if: operation request, result handshake and status bundle for accum_unit.
interface accum_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic sub;
  logic use_acc;
  logic clear;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] result;
  logic ovf;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] op_count;
  modport master (
    output in_valid, a, b, sub, use_acc, clear, out_ready,
    input  in_ready, out_valid, result, ovf, acc, op_count
  );
  modport slave (
    input  in_valid, a, b, sub, use_acc, clear, out_ready,
    output in_ready, out_valid, result, ovf, acc, op_count
  );
endinterface

// File: rtl/accum_unit.sv
// accum_unit: one-deep registered add/sub with accumulator and signed overflow flag.
// Defining ACCUM_UNIT_SAT_EN saturates result and acc on overflow instead of wrapping.
module accum_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  accum_unit_if.slave bus
);
  logic take;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res_n;
  logic ovf_n;
  assign bus.in_ready = !bus.out_valid | bus.out_ready;
  assign take = bus.in_valid & bus.in_ready;
  // a clear arriving with an accumulate operation zeroes operand A for that operation
  always_comb begin
    opa = bus.use_acc ? (bus.clear ? '0 : bus.acc) : bus.a;
    opb = bus.sub ? ~bus.b : bus.b;
    sum = opa + opb + {{(WIDTH-1){1'b0}}, bus.sub};
    ovf_n = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
`ifdef ACCUM_UNIT_SAT_EN
    res_n = ovf_n ? {opa[WIDTH-1], {(WIDTH-1){~opa[WIDTH-1]}}} : sum;
`else
    res_n = sum;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.result <= '0;
      bus.ovf <= 1'b0;
      bus.acc <= '0;
      bus.op_count <= '0;
    end else begin
      if (take) begin
        bus.result <= res_n;
        bus.ovf <= ovf_n;
        bus.acc <= res_n;
        bus.op_count <= bus.op_count + CNT_W'(1);
      end else if (bus.clear) begin
        bus.acc <= '0;
      end
      bus.out_valid <= take | (bus.out_valid & !bus.out_ready);
    end
  end
endmodule

// File: tb/tb_accum_unit.sv
// tb_accum_unit: directed and random scoreboard bench for accum_unit.
module tb_accum_unit;
  localparam int W = 32;
  localparam int C = 8;
  typedef struct {
    logic [31:0] r;
    logic o;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  accum_unit_if #(.WIDTH(W), .CNT_W(C)) bus ();
  accum_unit #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .reset(reset), .bus(bus));
  exp_t q[$];
  int ncmp = 0;
  int nfail = 0;
  logic mv = 1'b0;
  logic [31:0] macc = '0;
  logic [7:0] mcnt = '0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                       input logic s, input logic u, input logic c, input logic r);
    bus.in_valid = v;
    bus.a = ia;
    bus.b = ib;
    bus.sub = s;
    bus.use_acc = u;
    bus.clear = c;
    bus.out_ready = r;
  endtask
  function automatic logic [31:0] pick();
    int k;
    k = $urandom_range(0, 5);
    return k == 0 ? 32'h7fff_ffff : k == 1 ? 32'h8000_0000 : k == 2 ? 32'h0 :
           k == 3 ? 32'hffff_ffff : $urandom;
  endfunction
  // one clock: check handshake/result before the edge, update the model, check state after it
  task automatic cyc();
    logic take;
    logic [31:0] opa;
    longint sa, sb, x;
    exp_t e;
    #1;
    chk("in_ready", bus.in_ready, !mv || bus.out_ready);
    chk("out_valid", bus.out_valid, mv);
    if (mv && q.size() > 0) begin
      chk("result", bus.result, q[0].r);
      chk("ovf", bus.ovf, q[0].o);
    end
    take = bus.in_valid && (!mv || bus.out_ready);
    if (mv && bus.out_ready && q.size() > 0) void'(q.pop_front());
    if (take) begin
      opa = bus.use_acc ? (bus.clear ? 32'h0 : macc) : bus.a;
      sa = longint'($signed(opa));
      sb = longint'($signed(bus.b));
      x = bus.sub ? sa - sb : sa + sb;
      e.o = (x > 64'sd2147483647) || (x < -64'sd2147483648);
      e.r = x[31:0];
`ifdef ACCUM_UNIT_SAT_EN
      if (e.o) e.r = x < 0 ? 32'h8000_0000 : 32'h7fff_ffff;
`endif
      q.push_back(e);
      macc = e.r;
      mcnt++;
    end else if (bus.clear) begin
      macc = '0;
    end
    mv = take || (mv && !bus.out_ready);
    @(posedge clk);
    #1;
    chk("acc", bus.acc, macc);
    chk("op_count", bus.op_count, mcnt);
    @(negedge clk);
  endtask
  // reset asserted mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_acc", bus.acc, 0);
    chk("rst_op_count", bus.op_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    mv = 1'b0;
    macc = '0;
    mcnt = '0;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    do_reset();
    drive(1, 5, 3, 0, 0, 0, 1);
    cyc();
    chk("add_result", bus.result, 8);
    chk("add_ovf", bus.ovf, 0);
    chk("add_acc", bus.acc, 8);
    chk("add_count", bus.op_count, 1);
    drive(1, 0, 10, 1, 1, 0, 1);
    cyc();
    chk("accsub_result", bus.result, 32'hffff_fffe);
    chk("accsub_acc", bus.acc, 32'hffff_fffe);
    chk("accsub_ovf", bus.ovf, 0);
    drive(1, 32'h7fff_ffff, 1, 0, 0, 0, 1);
    cyc();
    chk("posovf_ovf", bus.ovf, 1);
`ifdef ACCUM_UNIT_SAT_EN
    chk("posovf_result", bus.result, 32'h7fff_ffff);
`else
    chk("posovf_result", bus.result, 32'h8000_0000);
`endif
    drive(1, 0, 32'h8000_0000, 1, 0, 0, 1);
    cyc();
    chk("minneg_ovf", bus.ovf, 1);
    drive(1, 32'h8000_0000, 1, 1, 0, 0, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(i + 40), 2, 0, 0, 0, 0);
      cyc();
    end
    chk("stall_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i + 100), 7, 1'(i), 0, 0, 1);
      cyc();
    end
    drive(1, 20, 0, 0, 0, 0, 1);
    cyc();
    drive(1, 0, 4, 0, 1, 1, 1);
    cyc();
    chk("clracc_result", bus.result, 4);
    chk("clracc_acc", bus.acc, 4);
    drive(0, 0, 0, 0, 0, 1, 1);
    cyc();
    chk("clr_acc", bus.acc, 0);
    chk("clr_result", bus.result, 4);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom), 1'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      cyc();
    end
    for (int i = 0; i < 255; i++) begin
      drive(1, pick(), pick(), 1'($urandom), 1'($urandom), 0, 1);
      cyc();
    end
    chk("stream_out_valid", bus.out_valid, 1);
    do_reset();
    drive(1, 5, 3, 0, 0, 0, 1);
    cyc();
    chk("again_result", bus.result, 8);
    chk("again_count", bus.op_count, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
